// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
//
// Contents:
//   STATE_*      3-bit FSM state encodings shared with the receiver
//   uart_state_e typed view of those encodings
//   IDLE_LEVEL   line level when nothing is being sent (mark)
//   START_LEVEL  line level of the start bit (space)
//   STOP_LEVEL   line level of the stop bit (mark)

package uart_tx_serializer_pkg;

    localparam logic [2:0] STATE_IDLE   = 3'd0;
    localparam logic [2:0] STATE_START  = 3'd1;
    localparam logic [2:0] STATE_DATA   = 3'd2;
    localparam logic [2:0] STATE_PARITY = 3'd3;
    localparam logic [2:0] STATE_STOP   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = STATE_IDLE,
        StStart  = STATE_START,
        StData   = STATE_DATA,
        StParity = STATE_PARITY,
        StStop   = STATE_STOP
    } uart_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter.
//
// Counts clock cycles while Enable is high and pulses Tick on the last cycle of
// each BAUD_DIVISOR-cycle bit period. The count restarts at every bit boundary
// and is held at zero while Enable is low, so it never runs past
// BAUD_DIVISOR-1.
//
// Parameters:
//   BAUD_DIVISOR  clock cycles per serial bit (2 or more)
// Ports:
//   clk     system clock
//   reset   asynchronous active-high reset
//   Enable  count while high; clear while low
//   Tick    one-cycle pulse on the final cycle of a bit period

module uart_baud_tick
    import uart_tx_serializer_pkg::*;
#(
    parameter int unsigned BAUD_DIVISOR = 5208
) (
    input  logic clk,
    input  logic reset,
    input  logic Enable,
    output logic Tick
);

    localparam int unsigned CNT_W = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIVISOR - 1);

    logic [CNT_W-1:0] bit_cnt;
    logic             at_last;

    assign at_last = (bit_cnt == CNT_LAST);
    assign Tick    = Enable && at_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (!Enable || at_last) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, WORD_LENGTH data bits LSB first,
// optional even parity bit, one stop bit.
//
// Configuration macro:
//   UART_TX_PARITY_EN  when defined, an even-parity bit (XOR of the latched
//                      word) is sent between the last data bit and the stop
//                      bit. Undefined gives 8N1 frames at the default width.
//
// Parameters:
//   WORD_LENGTH   data bits per frame
//   BAUD_DIVISOR  clock cycles per serial bit (2 or more)
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   Transmit    frame request, only looked at while Busy is low
//   Data_In     word to send, latched in the accepting cycle
//   Serial_Out  TX line, idle high (registered)
//   Busy        high while a frame is in progress (registered)
//   Done        one-cycle pulse in the first idle cycle after a frame

module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int unsigned WORD_LENGTH  = 8,
    parameter int unsigned BAUD_DIVISOR = 5208
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Transmit,
    input  logic [WORD_LENGTH-1:0] Data_In,
    output logic                   Serial_Out,
    output logic                   Busy,
    output logic                   Done
);

    localparam int unsigned IDX_W = $clog2(WORD_LENGTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LENGTH - 1);

    uart_state_e            state;
    logic [WORD_LENGTH-1:0] shift_reg;
    logic [WORD_LENGTH-1:0] shift_next;
    logic [IDX_W-1:0]       bit_idx;
    logic                   tick;
    logic                   timer_en;
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    assign shift_next = shift_reg >> 1;
    assign timer_en   = (state != StIdle);

    uart_baud_tick #(
        .BAUD_DIVISOR (BAUD_DIVISOR)
    ) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .Enable (timer_en),
        .Tick   (tick)
    );

    // Outputs are registered alongside the state so that Serial_Out always
    // reflects the state being held; each transition loads the level of the
    // state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            shift_reg  <= '0;
            bit_idx    <= '0;
            Serial_Out <= IDLE_LEVEL;
            Busy       <= 1'b0;
            Done       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (Transmit) begin
                        state      <= StStart;
                        shift_reg  <= Data_In;
                        bit_idx    <= '0;
                        Serial_Out <= START_LEVEL;
                        Busy       <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        // The shift register is consumed as bits go out, so
                        // parity is taken from the word as it is latched.
                        parity_bit <= ^Data_In;
`endif
                    end
                end
                StStart: begin
                    if (tick) begin
                        state      <= StData;
                        Serial_Out <= shift_reg[0];
                    end
                end
                StData: begin
                    if (tick) begin
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state      <= StParity;
                            Serial_Out <= parity_bit;
`else
                            state      <= StStop;
                            Serial_Out <= STOP_LEVEL;
`endif
                        end else begin
                            bit_idx    <= bit_idx + IDX_W'(1);
                            shift_reg  <= shift_next;
                            Serial_Out <= shift_next[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (tick) begin
                        state      <= StStop;
                        Serial_Out <= STOP_LEVEL;
                    end
                end
`endif
                StStop: begin
                    if (tick) begin
                        state      <= StIdle;
                        Serial_Out <= IDLE_LEVEL;
                        Busy       <= 1'b0;
                        Done       <= 1'b1;
                    end
                end
                default: begin
                    state      <= StIdle;
                    Serial_Out <= IDLE_LEVEL;
                    Busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer at WORD_LENGTH=8, BAUD_DIVISOR=4.
// Expected line traces come from a frame model built from the bit list
// {start, data LSB first, [parity], stop}, each bit repeated BAUD_DIVISOR times.

module tb_uart_tx_serializer;

    localparam int unsigned WL  = 8;
    localparam int unsigned DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif
    localparam int FRAME = (2 + WL + P) * DIV;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Transmit = 1'b0;
    logic [WL-1:0] Data_In = '0;
    logic          Serial_Out;
    logic          Busy;
    logic          Done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .WORD_LENGTH  (WL),
        .BAUD_DIVISOR (DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Transmit   (Transmit),
        .Data_In    (Data_In),
        .Serial_Out (Serial_Out),
        .Busy       (Busy),
        .Done       (Done)
    );

    // Expected line level for each cycle after the accepting edge; idle high after.
    function automatic logic [255:0] model_line(input logic [WL-1:0] w);
        logic [255:0] v;
        bit q[$];
        v = '1;
        q.push_back(1'b0);
        for (int i = 0; i < WL; i++) q.push_back(w[i]);
        if (P == 1) q.push_back(^w);
        q.push_back(1'b1);
        for (int b = 0; b < q.size(); b++)
            for (int k = 0; k < DIV; k++) v[b*DIV+k] = q[b];
        return v;
    endfunction

    // Present a request before an edge; the next posedge accepts it.
    task automatic start_frame(input logic [WL-1:0] w, input bit hold);
        @(negedge clk);
        Data_In  = w;
        Transmit = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) Transmit = 1'b0;
    endtask

    // Record n cycles of outputs, sampled on falling edges.
    task automatic capture(input int n, output logic [255:0] line, output int busy_n,
                           output int done_n, output int done_at);
        line = '1; busy_n = 0; done_n = 0; done_at = -1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            line[c] = Serial_Out;
            if (Busy === 1'b1) busy_n++;
            if (Done === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
        end
    endtask

    task automatic test_reset();
        logic [255:0] line;
        int busy_n, done_n, done_at;
        repeat (2) @(negedge clk);
        n_checks++;
        if (Serial_Out !== 1'b1) begin
            n_fail++; $display("FAIL reset_line: got %b want 1", Serial_Out);
        end
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", Busy);
        end
        n_checks++;
        if (Done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b want 0", Done);
        end
        // Request during the last edge that still sees reset high.
        @(negedge clk);
        Transmit = 1'b1;
        Data_In  = 8'h00;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        Transmit = 1'b0;
        capture(8, line, busy_n, done_n, done_at);
        n_checks++;
        if (line !== {256{1'b1}}) begin
            n_fail++; $display("FAIL release_line: got %h want all ones", line[7:0]);
        end
        n_checks++;
        if (busy_n !== 0) begin
            n_fail++; $display("FAIL release_busy: got %0d busy cycles want 0", busy_n);
        end
    endtask

    task automatic test_single_frame();
        logic [255:0] line;
        int busy_n, done_n, done_at;
        start_frame(8'hA5, 1'b0);
        capture(FRAME + 3, line, busy_n, done_n, done_at);
        n_checks++;
        if (line !== model_line(8'hA5)) begin
            n_fail++; $display("FAIL a5_line: got %h want %h", line, model_line(8'hA5));
        end
        n_checks++;
        if (busy_n !== FRAME) begin
            n_fail++; $display("FAIL a5_busy: got %0d want %0d", busy_n, FRAME);
        end
        n_checks++;
        if (done_n !== 1) begin
            n_fail++; $display("FAIL a5_done_count: got %0d want 1", done_n);
        end
        n_checks++;
        if (done_at !== FRAME) begin
            n_fail++; $display("FAIL a5_done_at: got %0d want %0d", done_at, FRAME);
        end
    endtask

    task automatic test_parity();
        logic [WL-1:0] words [2] = '{8'h07, 8'h03};
        logic          pbits [2] = '{1'b1, 1'b0};
        logic [255:0] line;
        int busy_n, done_n, done_at;
        for (int i = 0; i < 2; i++) begin
            start_frame(words[i], 1'b0);
            capture(FRAME + 3, line, busy_n, done_n, done_at);
            n_checks++;
            if (line !== model_line(words[i])) begin
                n_fail++;
                $display("FAIL parity_line %h: got %h want %h", words[i], line,
                         model_line(words[i]));
            end
            n_checks++;
            if (busy_n !== FRAME) begin
                n_fail++;
                $display("FAIL parity_busy %h: got %0d want %0d", words[i], busy_n, FRAME);
            end
`ifdef UART_TX_PARITY_EN
            n_checks++;
            if (line[(1 + WL) * DIV + 1] !== pbits[i]) begin
                n_fail++;
                $display("FAIL parity_bit %h: got %b want %b", words[i],
                         line[(1 + WL) * DIV + 1], pbits[i]);
            end
`else
            n_checks++;
            if (line[(1 + WL) * DIV + 1] !== 1'b1) begin
                n_fail++;
                $display("FAIL stop_after_data %h: got %b want 1", words[i],
                         line[(1 + WL) * DIV + 1]);
            end
            if (pbits[i] === 1'b0) Data_In = '0;
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] line, exp, exp2;
        int busy_n = 0, done_n = 0, done_at = -1;
        start_frame(8'h55, 1'b1);
        Data_In = 8'hAA;
        exp  = model_line(8'h55);
        exp2 = model_line(8'hAA);
        for (int i = 0; i < FRAME; i++) exp[FRAME+1+i] = exp2[i];
        line = '1;
        for (int c = 0; c < 2 * FRAME + 5; c++) begin
            @(negedge clk);
            line[c] = Serial_Out;
            if (Busy === 1'b1) busy_n++;
            if (Done === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (c == FRAME + 2) Transmit = 1'b0;
        end
        n_checks++;
        if (line !== exp) begin
            n_fail++; $display("FAIL b2b_line: got %h want %h", line, exp);
        end
        n_checks++;
        if (busy_n !== 2 * FRAME) begin
            n_fail++; $display("FAIL b2b_busy: got %0d want %0d", busy_n, 2 * FRAME);
        end
        n_checks++;
        if (done_n !== 2) begin
            n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_n);
        end
        n_checks++;
        if (done_at !== FRAME) begin
            n_fail++; $display("FAIL b2b_first_done: got %0d want %0d", done_at, FRAME);
        end
    endtask

    task automatic test_midframe_ignore();
        logic [WL-1:0] w;
        logic [255:0] line;
        int busy_n = 0, done_n = 0;
        w = WL'($urandom);
        start_frame(w, 1'b0);
        line = '1;
        for (int c = 0; c < FRAME + 6; c++) begin
            @(negedge clk);
            line[c] = Serial_Out;
            if (Busy === 1'b1) busy_n++;
            if (Done === 1'b1) done_n++;
            if (c == 14) begin
                Data_In  = ~w;
                Transmit = 1'b1;
            end
            if (c == 15) Transmit = 1'b0;
        end
        n_checks++;
        if (line !== model_line(w)) begin
            n_fail++; $display("FAIL ignore_line %h: got %h want %h", w, line, model_line(w));
        end
        n_checks++;
        if (busy_n !== FRAME) begin
            n_fail++; $display("FAIL ignore_busy: got %0d want %0d", busy_n, FRAME);
        end
        n_checks++;
        if (done_n !== 1) begin
            n_fail++; $display("FAIL ignore_done_count: got %0d want 1", done_n);
        end
    endtask

    task automatic test_reset_midframe();
        logic [WL-1:0] w;
        logic [255:0] line;
        int busy_n, done_n, done_at;
        w = WL'($urandom);
        start_frame(w, 1'b0);
        // Cycles 16..19 after acceptance carry data bit 3.
        repeat (18) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (Serial_Out !== 1'b1) begin
            n_fail++; $display("FAIL abort_line: got %b want 1", Serial_Out);
        end
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy: got %b want 0", Busy);
        end
        @(negedge clk);
        reset = 1'b0;
        capture(6, line, busy_n, done_n, done_at);
        n_checks++;
        if (done_n !== 0) begin
            n_fail++; $display("FAIL abort_done: got %0d pulses want 0", done_n);
        end
        n_checks++;
        if (line !== {256{1'b1}} || busy_n !== 0) begin
            n_fail++;
            $display("FAIL abort_idle: got line %h busy %0d want all ones busy 0",
                     line[5:0], busy_n);
        end
        w = ~w;
        start_frame(w, 1'b0);
        capture(FRAME + 3, line, busy_n, done_n, done_at);
        n_checks++;
        if (line !== model_line(w) || busy_n !== FRAME || done_at !== FRAME) begin
            n_fail++;
            $display("FAIL after_abort %h: got line %h busy %0d done_at %0d want %h %0d %0d",
                     w, line, busy_n, done_at, model_line(w), FRAME, FRAME);
        end
    endtask

    task automatic test_random();
        logic [WL-1:0] w;
        logic [255:0] line;
        int busy_n, done_n, done_at;
        for (int i = 0; i < 6; i++) begin
            w = WL'($urandom);
            start_frame(w, 1'b0);
            capture(FRAME + 2, line, busy_n, done_n, done_at);
            n_checks++;
            if (line !== model_line(w) || busy_n !== FRAME || done_n !== 1) begin
                n_fail++;
                $display("FAIL random %h: got line %h busy %0d done %0d want %h %0d 1",
                         w, line, busy_n, done_n, model_line(w), FRAME);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_midframe_ignore();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
